// File: rtl/card_dealer_if.sv
// Deal handshake between the counter/game logic and the card dealer.
// The master side drives requests and counter status; the slave side is the dealer.
interface card_dealer_if #(
    parameter int WIDTH = 12
) ();
    logic             i_Req;
    logic             i_Shuffle;
    logic [WIDTH-1:0] i_Seed;
    logic             i_TwoSec;
    logic             o_Zero;
    logic             o_Active;
    logic [3:0]       o_Card;
    logic [3:0]       o_Points;
    logic             o_Valid;
    logic             o_Busy;
    logic             o_DeckEmpty;

    modport master (
        output i_Req, i_Shuffle, i_Seed, i_TwoSec,
        input  o_Zero, o_Active, o_Card, o_Points, o_Valid, o_Busy, o_DeckEmpty
    );

    modport slave (
        input  i_Req, i_Shuffle, i_Seed, i_TwoSec,
        output o_Zero, o_Active, o_Card, o_Points, o_Valid, o_Busy, o_DeckEmpty
    );
endinterface

// File: rtl/card_dealer.sv
// LFSR card dealer: seeds from the counter, rejection-samples a rank, then holds for two seconds.
// Define CARD_DEALER_DECK_TRACK_EN for a finite shoe with per-rank limits and deck-empty flag.
module card_dealer #(
    parameter int          WIDTH     = 12,
    parameter int          DECKS     = 1,
    parameter logic [15:0] LFSR_INIT = 16'hACE1
) (
    input  logic        clk_50M,
    input  logic        i_Reset,
    card_dealer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [3:0] rank_points(input logic [3:0] r);
        return (r >= 4'd10) ? 4'd10 : r;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  card_q, card_d;
    logic [3:0]  points_q, points_d;
    logic        valid_q, valid_d;
    logic        zero_q, zero_d;
    logic        active_q, active_d;
    logic        busy_q, busy_d;

    logic [15:0] seed_ext_s;
    logic [15:0] mixed_s;
    logic [4:0]  cand_s;
    logic        rank_ok_s;
    logic        accept_s;
    logic        shuffle_req_s;
    logic        deck_empty_s;

    if (WIDTH >= 16) begin : g_seed_trunc
        assign seed_ext_s = bus.i_Seed[15:0];
    end else begin : g_seed_ext
        assign seed_ext_s = {{(16 - WIDTH){1'b0}}, bus.i_Seed};
    end

    assign mixed_s  = lfsr_q ^ seed_ext_s;
    assign cand_s   = {1'b0, lfsr_q[3:0]} + 5'd1;
    assign accept_s = (state_q == ST_DRAW) && rank_ok_s;

`ifdef CARD_DEALER_DECK_TRACK_EN
    localparam int CW = $clog2(4 * DECKS + 1);
    localparam int DW = $clog2(52 * DECKS + 1);

    // Index 0 and 14..15 exist only so any nibble can index safely; they never count.
    logic [CW-1:0] cnt_q [16];
    logic [DW-1:0] dealt_q;

    assign rank_ok_s     = (cand_s <= 5'd13) && (cnt_q[cand_s[3:0]] < CW'(4 * DECKS));
    assign shuffle_req_s = bus.i_Shuffle;
    assign deck_empty_s  = (dealt_q == DW'(52 * DECKS));

    // Shoe bookkeeping: per-rank usage and total dealt since the last shuffle.
    always_ff @(posedge clk_50M) begin
        if (i_Reset || (state_q == ST_IDLE && shuffle_req_s)) begin
            for (int r = 0; r < 16; r++) begin
                cnt_q[r] <= '0;
            end
            dealt_q <= '0;
        end else if (accept_s) begin
            cnt_q[cand_s[3:0]] <= cnt_q[cand_s[3:0]] + CW'(1);
            dealt_q            <= dealt_q + DW'(1);
        end
    end
`else
    assign rank_ok_s     = (cand_s <= 5'd13);
    assign shuffle_req_s = 1'b0;
    assign deck_empty_s  = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            state_q  <= ST_IDLE;
            lfsr_q   <= LFSR_INIT;
            card_q   <= 4'd0;
            points_q <= 4'd0;
            valid_q  <= 1'b0;
            zero_q   <= 1'b0;
            active_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            card_q   <= card_d;
            points_q <= points_d;
            valid_q  <= valid_d;
            zero_q   <= zero_d;
            active_q <= active_d;
            busy_q   <= busy_d;
        end
    end

    // Next state; outputs are computed one cycle early so they line up with the state they describe.
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        card_d   = card_q;
        points_d = points_q;
        valid_d  = 1'b0;
        zero_d   = 1'b0;
        active_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (shuffle_req_s) begin
                    state_d = ST_IDLE;
                end else if (bus.i_Req && !deck_empty_s) begin
                    lfsr_d  = (mixed_s == 16'd0) ? LFSR_INIT : mixed_s;
                    state_d = ST_DRAW;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAW: begin
                if (accept_s) begin
                    card_d   = cand_s[3:0];
                    points_d = rank_points(cand_s[3:0]);
                    valid_d  = 1'b1;
                    zero_d   = 1'b1;
                    state_d  = ST_HOLD;
                end else begin
                    lfsr_d   = lfsr_step(lfsr_q);
                end
            end
            ST_HOLD: begin
                // The two-second flag is stale while the counter is still being cleared.
                if (zero_q) begin
                    active_d = 1'b1;
                end else if (bus.i_TwoSec) begin
                    state_d  = ST_IDLE;
                end else begin
                    active_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign bus.o_Zero      = zero_q;
    assign bus.o_Active    = active_q;
    assign bus.o_Card      = card_q;
    assign bus.o_Points    = points_q;
    assign bus.o_Valid     = valid_q;
    assign bus.o_Busy      = busy_q;
    assign bus.o_DeckEmpty = deck_empty_s;

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: a reference model predicts each card and its latency,
// a monitor pops the prediction whenever o_Valid fires.
module tb_card_dealer;

    localparam logic [15:0] INIT = 16'hACE1;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    card_dealer_if #(.WIDTH(16)) bus ();

    card_dealer #(.WIDTH(16), .DECKS(1), .LFSR_INIT(INIT)) dut (
        .clk_50M (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    typedef struct {
        logic [3:0] card;
        logic [3:0] pts;
        int         req_cyc;
        int         lat;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_lfsr;
    int          m_cnt[16];
    int          m_dealt;
    int          obs_cnt[16];

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [3:0] m_points(input logic [3:0] r);
        return (r > 4'd10) ? 4'd10 : r;
    endfunction

    function automatic bit m_accept(input logic [15:0] v);
        logic [4:0] c;
        bit ok;
        c  = {1'b0, v[3:0]} + 5'd1;
        ok = (c <= 5'd13);
`ifdef CARD_DEALER_DECK_TRACK_EN
        ok = ok && (m_cnt[c[3:0]] < 4);
`endif
        return ok;
    endfunction

    function automatic bit m_empty();
`ifdef CARD_DEALER_DECK_TRACK_EN
        return (m_dealt == 52);
`else
        return 1'b0;
`endif
    endfunction

    // Output monitor: every o_Valid must match the oldest prediction, including latency.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst && bus.o_Valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("card", bus.o_Card, e.card);
                chk("points", bus.o_Points, e.pts);
                chk("latency", cyc - e.req_cyc, e.lat);
                obs_cnt[bus.o_Card]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        m_lfsr  = INIT;
        m_dealt = 0;
        for (int r = 0; r < 16; r++) m_cnt[r] = 0;
        sb.delete();
    endtask

    task automatic hold_phase();
        int n;
        n = 0;
        while (!bus.o_Zero && n < 2000) begin
            tick();
            n++;
        end
        chk("zero_seen", bus.o_Zero, 1);
        chk("active_on_zero", bus.o_Active, 0);
        bus.i_TwoSec = 1'b1;
        tick();
        chk("zero_one_cycle", bus.o_Zero, 0);
        chk("active_stale", bus.o_Active, 1);
        bus.i_TwoSec = 1'b0;
        bus.i_Req    = 1'b1;
        tick();
        bus.i_Req    = 1'b0;
        tick();
        chk("active_hold", bus.o_Active, 1);
        chk("busy_hold", bus.o_Busy, 1);
        bus.i_TwoSec = 1'b1;
        tick();
        bus.i_TwoSec = 1'b0;
        chk("active_fall", bus.o_Active, 0);
        chk("busy_fall", bus.o_Busy, 0);
    endtask

    task automatic deal(input logic [15:0] seed, input bit shuf);
        bit          do_shuf;
        bit          exp_deal;
        logic [15:0] m;
        int          rej;
        exp_t        e;
        do_shuf  = 1'b0;
        exp_deal = 1'b0;
`ifdef CARD_DEALER_DECK_TRACK_EN
        do_shuf = shuf;
`endif
        if (do_shuf) begin
            m_dealt = 0;
            for (int r = 0; r < 16; r++) m_cnt[r] = 0;
        end else if (!m_empty()) begin
            m = m_lfsr ^ seed;
            if (m == 16'd0) m = INIT;
            rej = 0;
            while (!m_accept(m)) begin
                m = m_step(m);
                rej++;
            end
            m_lfsr = m;
            e.card    = m[3:0] + 4'd1;
            e.pts     = m_points(e.card);
            e.req_cyc = cyc;
            e.lat     = 2 + rej;
            m_cnt[e.card]++;
            m_dealt++;
            sb.push_back(e);
            exp_deal = 1'b1;
        end
        bus.i_Req     = 1'b1;
        bus.i_Seed    = seed;
        bus.i_Shuffle = shuf;
        tick();
        bus.i_Req     = 1'b0;
        bus.i_Shuffle = 1'b0;
        if (exp_deal) begin
            hold_phase();
        end else begin
            repeat (3) tick();
            chk("no_deal_busy", bus.o_Busy, 0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        bus.i_Req     = 1'b0;
        bus.i_Shuffle = 1'b0;
        bus.i_Seed    = 16'd0;
        bus.i_TwoSec  = 1'b0;
        do_reset();

        chk("rst_card", bus.o_Card, 0);
        chk("rst_points", bus.o_Points, 0);
        chk("rst_valid", bus.o_Valid, 0);
        chk("rst_zero", bus.o_Zero, 0);
        chk("rst_active", bus.o_Active, 0);
        chk("rst_busy", bus.o_Busy, 0);
        chk("rst_empty", bus.o_DeckEmpty, 0);

        // ACE1 -> nibble 1 -> rank 2.
        deal(16'h0000, 1'b0);
        chk("first_card", bus.o_Card, 2);
        chk("first_points", bus.o_Points, 2);

        // ACEE rejects twice (15, 14) then B3BB gives a queen after 4 cycles.
        deal(16'h000F, 1'b0);
        chk("queen_card", bus.o_Card, 12);
        chk("queen_points", bus.o_Points, 10);

        deal(16'h000B, 1'b0);
        chk("ace_card", bus.o_Card, 1);
        chk("ace_points", bus.o_Points, 1);

        deal(16'h000A, 1'b0);
        chk("jack_card", bus.o_Card, 11);
        chk("jack_points", bus.o_Points, 10);

        // Seed equal to the LFSR zeroes it, so the fallback value is used.
        deal(m_lfsr, 1'b0);
        chk("zero_mix_card", bus.o_Card, 2);

        deal(16'h5A5A, 1'b1);
`ifdef CARD_DEALER_DECK_TRACK_EN
        chk("shuffle_keeps_card", bus.o_Card, 2);
`endif

        // Reset while drawing abandons the deal and restores the LFSR.
        bus.i_Req  = 1'b1;
        bus.i_Seed = 16'h1234;
        tick();
        bus.i_Req  = 1'b0;
        chk("busy_in_draw", bus.o_Busy, 1);
        do_reset();
        chk("mid_rst_card", bus.o_Card, 0);
        chk("mid_rst_busy", bus.o_Busy, 0);
        chk("mid_rst_valid", bus.o_Valid, 0);
        deal(16'h0000, 1'b0);
        chk("post_rst_card", bus.o_Card, 2);

`ifdef CARD_DEALER_DECK_TRACK_EN
        deal(16'h0000, 1'b1);
        for (int r = 0; r < 16; r++) obs_cnt[r] = 0;
        for (int i = 0; i < 52; i++) deal(16'($urandom), 1'b0);
        for (int r = 1; r <= 13; r++) chk($sformatf("rank_%0d_count", r), obs_cnt[r], 4);
        chk("deck_empty", bus.o_DeckEmpty, 1);
        deal(16'($urandom), 1'b0);
        deal(16'h0000, 1'b1);
        chk("deck_refilled", bus.o_DeckEmpty, 0);
        deal(16'($urandom), 1'b0);
`else
        for (int i = 0; i < 20; i++) deal(16'($urandom), 1'b0);
        chk("never_empty", bus.o_DeckEmpty, 0);
`endif

        repeat (4) tick();
        chk("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
